// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch unit: default address and
// instruction widths, the default reset PC, the queue-entry layout and a
// small helper for sizing occupancy counters.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_ADDR_W     = 4;
    localparam int FETCH_INST_W     = 8;
    localparam int FETCH_RESET_ADDR = 0;

    // One prefetch-queue entry at the default widths: the instruction word
    // and the address it was fetched from.
    typedef struct packed {
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int fetch_cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the two buses of the fetch unit:
//   ROM side    : rom_adrs, rom_rd (to ROM), rom_data (from ROM, 1-cycle latency)
//   decode side : inst, inst_pc, inst_valid (to decode), inst_ready (from decode)
// modport master : the fetch unit
// modport slave  : the environment (ROM + decode stage)
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 8
);
    logic [ADDR_W-1:0] rom_adrs;
    logic              rom_rd;
    logic [INST_W-1:0] rom_data;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        output rom_adrs, rom_rd, inst, inst_pc, inst_valid,
        input  rom_data, inst_ready
    );

    modport slave (
        input  rom_adrs, rom_rd, inst, inst_pc, inst_valid,
        output rom_data, inst_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular queue used as the prefetch buffer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push, din   : write din at the tail
//   pop         : drop the head (ignored when empty)
//   flush       : empty the queue; dominates push and pop
//   count       : current occupancy (0..DEPTH)
//   head        : entry at the head (meaningful only when count != 0)
// Push while full is legal only together with a pop; the caller's credit
// logic guarantees that.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    input  logic                          flush,
    output logic [fetch_cnt_w(DEPTH)-1:0] count,
    output logic [WIDTH-1:0]              head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = fetch_cnt_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] slot_data [DEPTH];
    logic             do_pop;

    // Explicit wrap so that non-trivial DEPTH=1 pointer widths still work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && (count_reg != '0);

    // One register per slot; contents are not reset because count gates them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    data_reg <= din;
                end
            end
            assign slot_data[gi] = data_reg;
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            count_next = count_reg + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign count = count_reg;
    assign head  = slot_data[rd_ptr_reg];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch unit: keeps the PC, issues reads to a 1-cycle-latency
// ROM, buffers returned instructions in a DEPTH-entry prefetch queue and
// presents the head to decode over valid/ready. A jump redirects the PC and
// squashes everything queued or in flight.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   isjump, jumpadrs  : redirect request and target
//   bus (master)      : rom_adrs/rom_rd/rom_data, inst/inst_pc/inst_valid/inst_ready
// Optional feature (macro FETCH_LINK_EN):
//   call_en : jump to jumpadrs and save the return address in a link register
//   ret_en  : jump to the link register
//   Priority rst > ret_en > call_en > isjump; all flush like isjump.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              ADDR_W     = FETCH_ADDR_W,
    parameter int              INST_W     = FETCH_INST_W,
    parameter int              DEPTH      = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(FETCH_RESET_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FETCH_LINK_EN
    input  logic              call_en,
    input  logic              ret_en,
`endif
    input  logic              isjump,
    input  logic [ADDR_W-1:0] jumpadrs,
    fetch_queue_if.master     bus
);
    localparam int CW = fetch_cnt_w(DEPTH);
    localparam int EW = INST_W + ADDR_W;

    logic [ADDR_W-1:0] pc_reg;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;

    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       credit_used;
    logic              jump_take;
    logic [ADDR_W-1:0] jump_target;

`ifdef FETCH_LINK_EN
    logic [ADDR_W-1:0] link_reg;
    logic [ADDR_W-1:0] ret_addr;

    // Address of whatever instruction decode would see after the current head.
    assign ret_addr    = head_valid   ? head[ADDR_W-1:0] + 1'b1 :
                         inflight_reg ? inflight_pc_reg : pc_reg;
    assign jump_take   = ret_en || call_en || isjump;
    assign jump_target = ret_en ? link_reg : jumpadrs;

    always_ff @(posedge clk) begin
        if (rst) begin
            link_reg <= RESET_ADDR;
        end else if (call_en && !ret_en) begin
            link_reg <= ret_addr;
        end
    end
`else
    assign jump_take   = isjump;
    assign jump_target = jumpadrs;
`endif

    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.inst_ready;

    // The credit counts the read still in flight and subtracts this cycle's
    // pop, so a full queue that is draining can keep issuing.
    assign credit_used = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight_reg);
    assign issue       = !rst && !jump_take && (credit_used < (CW+1)'(DEPTH));

    // A return arriving in a jump cycle belongs to the old stream.
    assign push = inflight_reg && !jump_take;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({bus.rom_data, inflight_pc_reg}),
        .pop   (pop),
        .flush (jump_take),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_ADDR;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
            end
            if (jump_take) begin
                pc_reg <= jump_target;
            end else if (issue) begin
                pc_reg <= pc_reg + 1'b1;
            end
        end
    end

    assign bus.rom_adrs   = pc_reg;
    assign bus.rom_rd     = issue;
    assign bus.inst_valid = head_valid;
    // Zero when empty so uninitialised slots never leak onto the bus.
    assign bus.inst       = head_valid ? head[EW-1:ADDR_W] : '0;
    assign bus.inst_pc    = head_valid ? head[ADDR_W-1:0]  : '0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int ADDR_W = 4;
    localparam int INST_W = 8;
    localparam int DEPTH  = 2;
    localparam logic [ADDR_W-1:0] RST_PC = 4'd0;

    logic              clk = 1'b0;
    logic              rst;
    logic              isjump;
    logic [ADDR_W-1:0] jumpadrs;

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    fetch_queue #(
        .ADDR_W     (ADDR_W),
        .INST_W     (INST_W),
        .DEPTH      (DEPTH),
        .RESET_ADDR (RST_PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef FETCH_LINK_EN
        .call_en  (1'b0),
        .ret_en   (1'b0),
`endif
        .isjump   (isjump),
        .jumpadrs (jumpadrs),
        .bus      (bus)
    );

    // ROM contents: ROM[a] = 0x10 + a, one cycle read latency.
    always @(posedge clk) begin
        if (bus.rom_rd) bus.rom_data <= 8'h10 + {4'h0, bus.rom_adrs};
    end

    int checks = 0;
    int passed = 0;

    // Reference model: next expected instruction address of the accepted
    // stream, and reads issued but not yet consumed since the last flush.
    logic [ADDR_W-1:0] exp_pc;
    int                outstanding;

    // Per-cycle samples (taken at the falling edge).
    logic              s_valid, s_rd, hs;
    logic [INST_W-1:0] s_inst;
    logic [ADDR_W-1:0] s_pc, s_adrs;
    logic [ADDR_W-1:0] exp_pc_now;
    logic [INST_W-1:0] exp_inst_now;

    task automatic step();
        @(negedge clk);
        s_valid = bus.inst_valid;
        s_inst  = bus.inst;
        s_pc    = bus.inst_pc;
        s_rd    = bus.rom_rd;
        s_adrs  = bus.rom_adrs;
        hs      = s_valid && bus.inst_ready && !rst;
        exp_pc_now   = exp_pc;
        exp_inst_now = 8'h10 + {4'h0, exp_pc};
        if (hs) exp_pc = exp_pc + 4'd1;
        if (rst) begin
            exp_pc = RST_PC;
            outstanding = 0;
        end else if (isjump) begin
            exp_pc = jumpadrs;
            outstanding = 0;
        end else begin
            outstanding = outstanding + int'(s_rd) - int'(hs);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; isjump = 1'b0; jumpadrs = '0; bus.inst_ready = 1'b0;
        exp_pc = RST_PC; outstanding = 0;
        step();
        step();
        checks++;
        if (s_rd !== 1'b0 || s_valid !== 1'b0 || s_inst !== 8'h00 || s_pc !== 4'h0)
            $display("FAIL reset: rom_rd=%b valid=%b inst=%h pc=%h, expected 0/0/00/0",
                     s_rd, s_valid, s_inst, s_pc);
        else passed++;
    endtask

    task automatic test_startup();
        rst = 1'b0; bus.inst_ready = 1'b1;
        step();
        checks++;
        if (s_rd !== 1'b1 || s_adrs !== RST_PC || s_valid !== 1'b0)
            $display("FAIL startup_c0: rom_rd=%b adrs=%h valid=%b, expected 1/%h/0",
                     s_rd, s_adrs, s_valid, RST_PC);
        else passed++;
        step();
        checks++;
        if (s_valid !== 1'b0) $display("FAIL startup_c1: valid=%b, expected 0", s_valid);
        else passed++;
        step();
        checks++;
        if (s_valid !== 1'b1 || s_inst !== 8'h10 || s_pc !== 4'h0)
            $display("FAIL startup_c2: valid=%b inst=%h pc=%h, expected 1/10/0",
                     s_valid, s_inst, s_pc);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (!hs || s_pc !== exp_pc_now || s_inst !== exp_inst_now)
                $display("FAIL stream: hs=%b pc=%h inst=%h, expected 1/%h/%h",
                         hs, s_pc, s_inst, exp_pc_now, exp_inst_now);
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [INST_W-1:0] held_inst;
        logic [ADDR_W-1:0] held_pc;
        bus.inst_ready = 1'b0;
        step();
        held_inst = s_inst; held_pc = s_pc;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (s_valid !== 1'b1 || s_inst !== held_inst || s_pc !== held_pc)
                $display("FAIL stall_hold: valid=%b inst=%h pc=%h, expected 1/%h/%h",
                         s_valid, s_inst, s_pc, held_inst, held_pc);
            else passed++;
        end
        checks++;
        if (s_rd !== 1'b0 || outstanding != DEPTH)
            $display("FAIL stall_full: rom_rd=%b held=%0d, expected 0/%0d",
                     s_rd, outstanding, DEPTH);
        else passed++;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (!hs || s_pc !== exp_pc_now || s_inst !== exp_inst_now)
                $display("FAIL stall_release: hs=%b pc=%h inst=%h, expected 1/%h/%h",
                         hs, s_pc, s_inst, exp_pc_now, exp_inst_now);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        bit seen15 = 0;
        bit done   = 0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (hs) begin
                checks++;
                if (s_pc !== exp_pc_now || s_inst !== exp_inst_now)
                    $display("FAIL wrap_stream: pc=%h inst=%h, expected %h/%h",
                             s_pc, s_inst, exp_pc_now, exp_inst_now);
                else passed++;
                if (seen15) begin
                    checks++;
                    if (s_pc !== 4'h0) $display("FAIL wrap: pc=%h, expected 0", s_pc);
                    else passed++;
                    done = 1;
                end
                if (s_pc == 4'hF) seen15 = 1;
            end
        end
        if (!done) begin
            checks++;
            $display("FAIL wrap_timeout: wrap not seen, seen15=%b", seen15);
        end
    endtask

    // Jump to target after holding decode off for stall_cycles (0 = jump
    // straight out of streaming with a read in flight).
    task automatic test_jump(input logic [ADDR_W-1:0] target, input int stall_cycles);
        bus.inst_ready = 1'b0;
        for (int i = 0; i < stall_cycles; i++) step();
        isjump = 1'b1; jumpadrs = target; bus.inst_ready = (stall_cycles != 0);
        step();
        checks++;
        if (s_rd !== 1'b0) $display("FAIL jump_noissue: rom_rd=%b, expected 0", s_rd);
        else passed++;
        if (hs) begin
            checks++;
            if (s_pc !== exp_pc_now || s_inst !== exp_inst_now)
                $display("FAIL jump_hs: pc=%h inst=%h, expected %h/%h",
                         s_pc, s_inst, exp_pc_now, exp_inst_now);
            else passed++;
        end
        isjump = 1'b0; bus.inst_ready = 1'b1;
        step();
        checks++;
        if (s_rd !== 1'b1 || s_adrs !== target || s_valid !== 1'b0)
            $display("FAIL jump_n1: rom_rd=%b adrs=%h valid=%b, expected 1/%h/0",
                     s_rd, s_adrs, s_valid, target);
        else passed++;
        step();
        checks++;
        if (s_valid !== 1'b0) $display("FAIL jump_n2: valid=%b, expected 0", s_valid);
        else passed++;
        step();
        checks++;
        if (s_valid !== 1'b1 || s_pc !== target || s_inst !== 8'h10 + {4'h0, target})
            $display("FAIL jump_n3: valid=%b pc=%h inst=%h, expected 1/%h/%h",
                     s_valid, s_pc, s_inst, target, 8'h10 + {4'h0, target});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (!hs || s_pc !== exp_pc_now || s_inst !== exp_inst_now)
                $display("FAIL jump_stream: hs=%b pc=%h inst=%h, expected 1/%h/%h",
                         hs, s_pc, s_inst, exp_pc_now, exp_inst_now);
            else passed++;
        end
    endtask

    task automatic test_midreset();
        bus.inst_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1; bus.inst_ready = 1'b0;
        step();
        rst = 1'b0; bus.inst_ready = 1'b1;
        step();
        checks++;
        if (s_valid !== 1'b0 || s_inst !== 8'h00 || s_pc !== 4'h0 ||
            s_rd !== 1'b1 || s_adrs !== RST_PC)
            $display("FAIL midreset: valid=%b inst=%h pc=%h rd=%b adrs=%h, expected 0/00/0/1/%h",
                     s_valid, s_inst, s_pc, s_rd, s_adrs, RST_PC);
        else passed++;
        step();
        step();
        checks++;
        if (s_valid !== 1'b1 || s_pc !== RST_PC || s_inst !== 8'h10)
            $display("FAIL midreset_restart: valid=%b pc=%h inst=%h, expected 1/%h/10",
                     s_valid, s_pc, s_inst, RST_PC);
        else passed++;
    endtask

    task automatic test_random();
        logic              p_valid = 1'b0, p_ready = 1'b0, p_jump = 1'b0;
        logic [INST_W-1:0] p_inst = '0;
        logic [ADDR_W-1:0] p_pc = '0;
        for (int i = 0; i < 400; i++) begin
            bus.inst_ready = ($urandom_range(0, 9) < 7);
            isjump   = ($urandom_range(0, 19) == 0);
            jumpadrs = ADDR_W'($urandom);
            step();
            if (hs) begin
                checks++;
                if (s_pc !== exp_pc_now || s_inst !== exp_inst_now)
                    $display("FAIL random_stream: cyc=%0d pc=%h inst=%h, expected %h/%h",
                             i, s_pc, s_inst, exp_pc_now, exp_inst_now);
                else passed++;
            end
            if (p_valid && !p_ready && !p_jump) begin
                checks++;
                if (s_valid !== 1'b1 || s_inst !== p_inst || s_pc !== p_pc)
                    $display("FAIL random_hold: cyc=%0d valid=%b inst=%h pc=%h, expected 1/%h/%h",
                             i, s_valid, s_inst, s_pc, p_inst, p_pc);
                else passed++;
            end
            checks++;
            if (outstanding > DEPTH || outstanding < 0)
                $display("FAIL random_overrun: cyc=%0d held=%0d, expected 0..%0d",
                         i, outstanding, DEPTH);
            else passed++;
            p_valid = s_valid; p_ready = bus.inst_ready; p_jump = isjump;
            p_inst = s_inst; p_pc = s_pc;
        end
        isjump = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_wrap();
        test_jump(4'd9, 0);
        test_jump(4'd3, 4);
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
